// File: rtl/sens_timing_mon.sv
`default_nettype none
// ============================================================================
// Module   : sens_timing_mon
// Purpose  : Observe-only timing monitor for the sensor bus. Each frame it
//            measures pixels per line, lines per frame and a pixel-data
//            checksum, compares them with the expected geometry and keeps
//            sticky error flags.
// Ports    : clk_72m     - system clock, rising edge
//            xreset      - asynchronous active-low reset
//            fv_in       - frame valid level
//            lv_in       - line valid level
//            data_in     - pixel data [DATA_W]
//            err_clr     - one-cycle pulse, clears the sticky errors
//            locked      - high once the first complete frame was measured
//            frame_done  - one-cycle pulse when the results update
//            meas_hpix   - pixel count of the last line of the last frame
//            meas_vline  - line count of the last frame
//            frame_cnt   - completed-frame counter (wraps)
//            frame_sum   - sum of valid pixel data of the last frame (mod 2^32)
//            err_hpix    - sticky: a line length differed from H_ACT
//            err_vline   - sticky: a frame line count differed from V_ACT
//            err_lv_out  - sticky: lv was high while fv was low
// Revision : 1.0 - initial release
// ============================================================================
module sens_timing_mon #(
    parameter int DATA_W = 12,
    parameter int H_ACT  = 1920,
    parameter int V_ACT  = 1080,
    parameter int CNT_W  = 16
) (
    input  logic              clk_72m,
    input  logic              xreset,
    input  logic              fv_in,
    input  logic              lv_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              err_clr,
    output logic              locked,
    output logic              frame_done,
    output logic [CNT_W-1:0]  meas_hpix,
    output logic [CNT_W-1:0]  meas_vline,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [31:0]       frame_sum,
    output logic              err_hpix,
    output logic              err_vline,
    output logic              err_lv_out
);

    localparam logic [1:0] S_SYNC  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FRAME = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] c_h_act   = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] c_v_act   = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    // ------------------------------------------------------------------------
    // Input stage and edge-detect registers
    // ------------------------------------------------------------------------
    logic              fv_q;
    logic              lv_q;
    logic [DATA_W-1:0] data_q;
    logic              fv_dly_q;
    logic              lv_dly_q;
    // Marks that fv_q holds a real sample; without it the reset value of fv_q
    // would look like "fv low" and let a partial frame through after reset.
    logic              primed_q;

    always_ff @(posedge clk_72m or negedge xreset) begin
        if (!xreset) begin
            fv_q     <= 1'b0;
            lv_q     <= 1'b0;
            data_q   <= '0;
            fv_dly_q <= 1'b0;
            lv_dly_q <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            fv_q     <= fv_in;
            lv_q     <= lv_in;
            data_q   <= data_in;
            fv_dly_q <= fv_q;
            lv_dly_q <= lv_q;
            primed_q <= 1'b1;
        end
    end

    logic w_fv_rise;
    logic w_fv_fall;
    logic w_lv_fall;
    logic w_pix;

    assign w_fv_rise = fv_q & ~fv_dly_q;
    assign w_fv_fall = ~fv_q & fv_dly_q;
    assign w_lv_fall = ~lv_q & lv_dly_q;
    assign w_pix     = fv_q & lv_q;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    logic [1:0] state_q;
    logic [1:0] state_d;

    always_ff @(posedge clk_72m or negedge xreset) begin
        if (!xreset) begin
            state_q <= S_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SYNC:  if (primed_q && !fv_q) state_d = S_WAIT;
            S_WAIT:  if (w_fv_rise)         state_d = S_FRAME;
            S_FRAME: if (w_fv_fall)         state_d = S_DONE;
            // A new frame may begin in the publish cycle (1-cycle fv gap).
            S_DONE:  state_d = w_fv_rise ? S_FRAME : S_WAIT;
            default: state_d = S_SYNC;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: decoded controls
    // ------------------------------------------------------------------------
    logic w_frame_start;
    logic w_accum;
    logic w_publish;
    logic w_lv_check;

    always_comb begin
        w_frame_start = 1'b0;
        w_accum       = 1'b0;
        w_publish     = 1'b0;
        w_lv_check    = 1'b0;
        case (state_q)
            S_WAIT: begin
                w_frame_start = w_fv_rise;
                w_lv_check    = 1'b1;
            end
            S_FRAME: begin
                w_accum    = 1'b1;
                w_lv_check = 1'b1;
            end
            S_DONE: begin
                w_publish     = 1'b1;
                w_frame_start = w_fv_rise;
                w_lv_check    = 1'b1;
            end
            default: begin
                w_frame_start = 1'b0;
            end
        endcase
    end

    // A line ends on lv falling, or when fv falls while lv is still high.
    logic w_line_end;
    assign w_line_end = w_accum & (w_lv_fall | (w_fv_fall & lv_q));

    // ------------------------------------------------------------------------
    // Frame accumulators
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] pix_q,       pix_d;
    logic [CNT_W-1:0] line_q,      line_d;
    logic [CNT_W-1:0] last_hpix_q, last_hpix_d;
    logic [31:0]      sum_q,       sum_d;
    logic             hpix_pend_q, hpix_pend_d;

    always_comb begin
        pix_d       = pix_q;
        line_d      = line_q;
        last_hpix_d = last_hpix_q;
        sum_d       = sum_q;
        hpix_pend_d = hpix_pend_q;
        if (w_frame_start) begin
            // The start cycle may already carry a pixel; count it rather
            // than drop it.
            pix_d       = w_pix ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
            line_d      = '0;
            sum_d       = w_pix ? 32'(data_q) : 32'd0;
            hpix_pend_d = 1'b0;
        end else if (w_accum) begin
            if (w_line_end) begin
                line_d      = (line_q == c_cnt_max) ? line_q : line_q + 1'b1;
                last_hpix_d = pix_q;
                pix_d       = '0;
                if (pix_q != c_h_act) begin
                    hpix_pend_d = 1'b1;
                end
            end else if (w_pix) begin
                pix_d = (pix_q == c_cnt_max) ? pix_q : pix_q + 1'b1;
            end
            if (w_pix) begin
                sum_d = sum_q + 32'(data_q);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Published results and sticky errors
    // ------------------------------------------------------------------------
    logic             locked_q,     locked_d;
    logic             frame_done_q, frame_done_d;
    logic [CNT_W-1:0] meas_hpix_q,  meas_hpix_d;
    logic [CNT_W-1:0] meas_vline_q, meas_vline_d;
    logic [CNT_W-1:0] frame_cnt_q,  frame_cnt_d;
    logic [31:0]      frame_sum_q,  frame_sum_d;
    logic             err_hpix_q,   err_hpix_d;
    logic             err_vline_q,  err_vline_d;
    logic             err_lv_q,     err_lv_d;

    always_comb begin
        frame_done_d = w_publish;
        locked_d     = locked_q | w_publish;
        meas_hpix_d  = w_publish ? last_hpix_q        : meas_hpix_q;
        meas_vline_d = w_publish ? line_q             : meas_vline_q;
        frame_sum_d  = w_publish ? sum_q              : frame_sum_q;
        frame_cnt_d  = w_publish ? frame_cnt_q + 1'b1 : frame_cnt_q;
        // Setting takes priority over a simultaneous clear.
        err_hpix_d   = (w_publish & hpix_pend_q) | (err_hpix_q & ~err_clr);
        err_vline_d  = (w_publish & (line_q != c_v_act)) | (err_vline_q & ~err_clr);
        err_lv_d     = (w_lv_check & lv_q & ~fv_q) | (err_lv_q & ~err_clr);
    end

    always_ff @(posedge clk_72m or negedge xreset) begin
        if (!xreset) begin
            pix_q        <= '0;
            line_q       <= '0;
            last_hpix_q  <= '0;
            sum_q        <= '0;
            hpix_pend_q  <= 1'b0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
            meas_hpix_q  <= '0;
            meas_vline_q <= '0;
            frame_cnt_q  <= '0;
            frame_sum_q  <= '0;
            err_hpix_q   <= 1'b0;
            err_vline_q  <= 1'b0;
            err_lv_q     <= 1'b0;
        end else begin
            pix_q        <= pix_d;
            line_q       <= line_d;
            last_hpix_q  <= last_hpix_d;
            sum_q        <= sum_d;
            hpix_pend_q  <= hpix_pend_d;
            locked_q     <= locked_d;
            frame_done_q <= frame_done_d;
            meas_hpix_q  <= meas_hpix_d;
            meas_vline_q <= meas_vline_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_sum_q  <= frame_sum_d;
            err_hpix_q   <= err_hpix_d;
            err_vline_q  <= err_vline_d;
            err_lv_q     <= err_lv_d;
        end
    end

    assign locked     = locked_q;
    assign frame_done = frame_done_q;
    assign meas_hpix  = meas_hpix_q;
    assign meas_vline = meas_vline_q;
    assign frame_cnt  = frame_cnt_q;
    assign frame_sum  = frame_sum_q;
    assign err_hpix   = err_hpix_q;
    assign err_vline  = err_vline_q;
    assign err_lv_out = err_lv_q;

endmodule
`default_nettype wire

// File: doc/sens_timing_mon.md
Name: sens_timing_mon

Overview:
Sensor-bus timing monitor on the output of add_nrsr (fe_sens_bus_out), clocked by clk_72m. Per frame it measures pixels per line, lines per frame and a pixel-data checksum. It compares the measurements against expected geometry and raises sticky error flags. It is observe-only: it drives nothing back onto the sensor bus and is instanced at top level and in tb_top.

Parameters:
DATA_W, 12, pixel data width
H_ACT, 1920, expected pixels per line
V_ACT, 1080, expected lines per frame
CNT_W, 16, width of all measurement counters

Ports:
clk_72m  in  1  system clock, all logic on rising edge
xreset  in  1  asynchronous active-low reset
fv_in  in  1  frame valid level, taken from fe_sens_bus_out
lv_in  in  1  line valid level, taken from fe_sens_bus_out
data_in  in  DATA_W  pixel data, taken from fe_sens_bus_out
err_clr  in  1  one-cycle pulse, clears sticky errors
locked  out  1  high once the first complete frame has been measured
frame_done  out  1  one-cycle pulse when results update
meas_hpix  out  CNT_W  pixel count of the last line of the last frame
meas_vline  out  CNT_W  line count of the last frame
frame_cnt  out  CNT_W  completed-frame counter
frame_sum  out  32  sum of data_in over valid pixels of the last frame
err_hpix  out  1  sticky: some line length differed from H_ACT
err_vline  out  1  sticky: frame line count differed from V_ACT
err_lv_out  out  1  sticky: lv_in was high while fv_in was low

Behaviour:
- Reset (xreset=0, asynchronous): every output goes to 0, FSM goes to S_SYNC, and all internal counters and input registers clear. Reset mid-frame discards that frame.
- Input stage: fv_in, lv_in and data_in are registered once (fv_r, lv_r, data_r). A second register on fv_r/lv_r provides edge detection. All decisions use the registered values.
- FSM:
  - S_SYNC: wait for fv_r=0, then go to S_WAIT. This rejects the partial frame seen after reset.
  - S_WAIT: on rising edge of fv_r, clear the frame accumulators and go to S_FRAME.
  - S_FRAME: accumulate. On falling edge of fv_r, go to S_DONE.
  - S_DONE: lasts one cycle, publishes results, then returns to S_WAIT.
- Pixel counter: in S_FRAME it increments each cycle fv_r&lv_r=1, saturating at 2^CNT_W-1, and resets to 0 at the start of each line.
- Line end is the falling edge of lv_r. A falling fv_r with lv_r still high also counts as a line end (truncated line). At each line end:
  - the line counter increments (saturating);
  - the pixel count is held as last_hpix;
  - if the count is not H_ACT, an error pending flag is set.
- Checksum: frame_sum accumulator adds zero-extended data_r when fv_r&lv_r, modulo 2^32.
- S_DONE cycle updates:
  - frame_done=1;
  - meas_hpix=last_hpix, meas_vline=line count, frame_sum=accumulator;
  - frame_cnt increments, wrapping 0xFFFF to 0;
  - locked=1, held until reset;
  - err_hpix is set if a pixel error was pending;
  - err_vline is set if line count is not V_ACT.
- Latency: frame_done is high in the cycle after the third rising edge at which fv_in is sampled low (1 input register + 1 edge register + S_DONE).
- Consecutive frames: fv_in low for 1 cycle between frames must still be measured. S_DONE overlapping a new fv rising edge must not lose that edge; the next frame starts directly from S_DONE.
- err_lv_out: set in any state except S_SYNC when lv_r=1 and fv_r=0.
- Zero-line frame (fv high, lv never high): meas_vline=0 and err_vline=1 (V_ACT is never 0). meas_hpix keeps its previous value.
- Sticky errors: err_clr clears all three. If a set condition occurs in the same cycle as err_clr, set wins.
- Outputs are held between frame_done pulses.

Test Plan:
1. H_ACT=8, V_ACT=4. Release reset mid-frame, then send 2 full frames of 4x8 with data=1. Response: no frame_done for the partial frame; 2 frame_done pulses; frame_cnt=2, meas_hpix=8, meas_vline=4, frame_sum=32, no errors, locked=1 after the first pulse.
2. Frame with line 2 of 7 pixels, all others 8. Response: err_hpix=1, meas_hpix=8, err_vline=0. Pulse err_clr, then send a good frame; err_hpix stays 0.
3. Frame with 5 lines of 8 pixels. Response: meas_vline=5, err_vline=1. fv drop with lv high on the last line (3 pixels): meas_hpix=3, err_hpix=1.
4. lv pulse of 2 cycles between frames with fv=0. Response: err_lv_out=1. err_clr asserted in the same cycle as a new violation leaves err_lv_out=1.
5. Back-to-back frames with a 1-cycle fv gap, data ramp 0..31. Response: both frames measured, each with frame_sum=496, and frame_done timing exactly as specified.
6. Assert xreset mid-frame after 2 good frames. Response: all outputs 0 immediately and locked=0. The next complete frame gives frame_cnt=1.
